counter_arbiter: RTL

- Shares one free-running-style up-counter datapath (same form as the team's `counter`: async reset, enable, +1 wrap) among N requesters.
- Each requester asks for an interval of `len` clock cycles. The controller grants round-robin, runs the shared counter for that many enabled cycles, then pulses `done` back to the winner.
- Sits between timeout/delay clients and the single shared counter instance.

---
 rtl/counter_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that lends one shared up-counter to N interval requesters.
// Each winner gets len cycles of counting, then a one-cycle done pulse.
module counter_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N*W-1:0] len,
    input  logic         pause,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [W-1:0] cnt,
    output logic [N-1:0] done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state, state_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [IW-1:0] owner, owner_d;
    logic [IW-1:0] pick;
    logic [IW-1:0] ptr_nxt;
    logic [W-1:0]  len_sel, len_sel_d;
    logic [W-1:0]  len_pick;
    logic [W-1:0]  cnt_d;
    logic [N-1:0]  grant_d;
    logic          found;

    // First set request at or after ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign len_pick = len[int'(pick)*W +: W];
    assign ptr_nxt  = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        cnt_d     = cnt;
        len_sel_d = len_sel;
        owner_d   = owner;
        ptr_d     = ptr;
        unique case (state)
            IDLE: begin
                cnt_d   = '0;
                grant_d = '0;
                if (found) begin
                    owner_d   = pick;
                    len_sel_d = len_pick;
                    grant_d   = N'(1) << pick;
                    state_d   = (len_pick == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!req[owner]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = ptr_nxt;
                end else if (!pause) begin
                    if (cnt == len_sel - W'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt + W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
                ptr_d   = ptr_nxt;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            cnt     <= '0;
            len_sel <= '0;
            owner   <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            cnt     <= cnt_d;
            len_sel <= len_sel_d;
            owner   <= owner_d;
            ptr     <= ptr_d;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE) ? grant : '0;

endmodule
